// File: rtl/bist_pkg.sv
// Shared switch/BIST constants and the debounce counter width helper.
package bist_pkg;

  localparam int SW_WIDTH        = 4;
  localparam int DB_CYCLES_SIM   = 10;
  localparam int DB_CYCLES_HW    = 1_000_000;
  localparam int SYNC_STAGES_DEF = 2;

  // Counter must hold 0..cycles-1; a single-cycle debounce still needs one bit.
  function automatic int db_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch conditioning bundle: raw pins in, clean levels/edges/status out.
// Carries chg_cnt only when SW_DEBOUNCE_CHGCNT_EN is defined.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);

  // No handshake: sw_raw is sampled every clk edge; outputs are levels and
  // single-cycle pulses valid on every cycle, with no ready/back-pressure.
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_any;
  logic             stable;
`ifdef SW_DEBOUNCE_CHGCNT_EN
  logic [7:0]       chg_cnt;
`endif

  modport master (
    output sw_raw,
    input  sw_db,
    input  sw_rise,
    input  sw_fall,
    input  sw_any,
`ifdef SW_DEBOUNCE_CHGCNT_EN
    input  chg_cnt,
`endif
    input  stable
  );

  modport slave (
    input  sw_raw,
    output sw_db,
    output sw_rise,
    output sw_fall,
    output sw_any,
`ifdef SW_DEBOUNCE_CHGCNT_EN
    output chg_cnt,
`endif
    output stable
  );

endinterface

// File: rtl/sw_db_bit.sv
// One switch bit: synchronizer chain, qualification counter, clean level and
// registered rise/fall pulses.
module sw_db_bit
  import bist_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic idle
);

  localparam int            CW      = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;
  logic                   differ;
  logic                   qualify;

  assign s       = sync[SYNC_STAGES-1];
  assign differ  = (s != db);
  assign qualify = differ && (cnt == CNT_MAX);
  assign idle    = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Any bounce back to the accepted level restarts qualification from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= qualify &  s;
      fall <= qualify & ~s;
      if (!differ) begin
        cnt <= '0;
      end else if (qualify) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Per-bit switch synchronizer/debouncer feeding the BIST sw input.
// Optional activity counter chg_cnt when SW_DEBOUNCE_CHGCNT_EN is defined.
module sw_debounce
  import bist_pkg::*;
#(
  parameter int WIDTH       = SW_WIDTH,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_SIM
) (
  input  logic           clk,
  input  logic           rst,
  sw_debounce_if.slave   sw
);

  logic [WIDTH-1:0] idle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_db_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .raw  (sw.sw_raw[i]),
      .db   (sw.sw_db[i]),
      .rise (sw.sw_rise[i]),
      .fall (sw.sw_fall[i]),
      .idle (idle[i])
    );
  end

  assign sw.sw_any = |sw.sw_db;
  assign sw.stable = &idle;

`ifdef SW_DEBOUNCE_CHGCNT_EN
  logic [7:0] chg_cnt_q;
  logic       any_edge;

  // One count per active cycle regardless of how many bits moved together.
  assign any_edge = |(sw.sw_rise | sw.sw_fall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_cnt_q <= '0;
    end else if (any_edge) begin
      chg_cnt_q <= chg_cnt_q + 8'd1;
    end
  end

  assign sw.chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with default parameters (4 bits, 2 sync, 10 db).
// Build with SW_DEBOUNCE_CHGCNT_EN defined to also check chg_cnt.
module tb_sw_debounce;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [W-1:0] model_db;

  sw_debounce_if #(.WIDTH(W)) sw_bus ();

  sw_debounce #(
    .WIDTH       (W),
    .SYNC_STAGES (2),
    .DB_CYCLES   (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a new raw level and follow it for 13 edges. e=0 is the capturing
  // edge; the new level must appear after e=11 with a one-cycle pulse there.
  task automatic run_change(input string tag, input logic [W-1:0] raw,
                            input logic [W-1:0] exp_rise, input logic [W-1:0] exp_fall);
    logic [W-1:0] old_db;
    logic [W-1:0] edb;
    logic         moving;
    old_db = model_db;
    moving = (raw != old_db);
    sw_bus.sw_raw = raw;
    for (int e = 0; e <= 12; e++) begin
      tick();
      edb = (e >= 11) ? raw : old_db;
      check({tag, "_db"}, 32'(sw_bus.sw_db), 32'(edb));
      check({tag, "_rise"}, 32'(sw_bus.sw_rise), (e == 11) ? 32'(exp_rise) : 32'd0);
      check({tag, "_fall"}, 32'(sw_bus.sw_fall), (e == 11) ? 32'(exp_fall) : 32'd0);
      check({tag, "_any"}, 32'(sw_bus.sw_any), 32'(|edb));
      check({tag, "_stable"}, 32'(sw_bus.stable),
            (moving && e >= 2 && e <= 10) ? 32'd0 : 32'd1);
    end
    model_db = raw;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    model_db = '0;
    rst      = 1'b1;
    sw_bus.sw_raw = '0;

    // 1. reset then idle
    repeat (3) tick();
    check("rst_db", 32'(sw_bus.sw_db), 32'd0);
    check("rst_stable", 32'(sw_bus.stable), 32'd1);
    check("rst_any", 32'(sw_bus.sw_any), 32'd0);
`ifdef SW_DEBOUNCE_CHGCNT_EN
    check("rst_chg", 32'(sw_bus.chg_cnt), 32'd0);
`endif
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      check("idle_pulse", 32'({sw_bus.sw_rise, sw_bus.sw_fall}), 32'd0);
      check("idle_db", 32'(sw_bus.sw_db), 32'd0);
      check("idle_stable", 32'(sw_bus.stable), 32'd1);
    end

    // 2. clean press, then release back to zero
    run_change("press", 4'b0101, 4'b0101, 4'b0000);
    run_change("unpress", 4'b0000, 4'b0000, 4'b0101);

    // 3. bounce on bit 2 with a 3-cycle half period is always rejected
    for (int c = 0; c < 40; c++) begin
      sw_bus.sw_raw = ((c / 3) % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      check("bounce_db", 32'(sw_bus.sw_db), 32'd0);
      check("bounce_rise", 32'(sw_bus.sw_rise), 32'd0);
    end
    sw_bus.sw_raw = '0;
    for (int c = 0; c < 15; c++) begin
      tick();
      check("bounce_settle_db", 32'(sw_bus.sw_db), 32'd0);
      check("bounce_settle_pulse", 32'({sw_bus.sw_rise, sw_bus.sw_fall}), 32'd0);
    end
    check("bounce_stable", 32'(sw_bus.stable), 32'd1);

    // 4. release one bit from all-pressed; sw_any stays high
    run_change("all", 4'b1111, 4'b1111, 4'b0000);
    run_change("release", 4'b1110, 4'b0000, 4'b0001);
    run_change("clear", 4'b0000, 4'b0000, 4'b1110);

    // 5. reset in the middle of qualification discards the pending change
    sw_bus.sw_raw = 4'b1000;
    repeat (6) tick();
    check("midq_db", 32'(sw_bus.sw_db), 32'd0);
    check("midq_stable", 32'(sw_bus.stable), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_db", 32'(sw_bus.sw_db), 32'd0);
    check("midrst_stable", 32'(sw_bus.stable), 32'd1);
`ifdef SW_DEBOUNCE_CHGCNT_EN
    check("midrst_chg", 32'(sw_bus.chg_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;
    run_change("requal", 4'b1000, 4'b1000, 4'b0000);
`ifdef SW_DEBOUNCE_CHGCNT_EN
    check("chg_after_requal", 32'(sw_bus.chg_cnt), 32'd1);
`endif

    // 6. three single-bit changes, then a two-bit simultaneous change
    run_change("add0", 4'b1001, 4'b0001, 4'b0000);
    run_change("add1", 4'b1011, 4'b0010, 4'b0000);
    run_change("add2", 4'b1111, 4'b0100, 4'b0000);
    run_change("drop01", 4'b1100, 4'b0000, 4'b0011);
`ifdef SW_DEBOUNCE_CHGCNT_EN
    check("chg_total", 32'(sw_bus.chg_cnt), 32'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Upstream conditioning stage for the switch-driven BIST/LED path. It synchronizes raw board switches into the clk domain and debounces each bit independently. Its outputs are clean switch levels plus one-cycle edge pulses. sw_db drives the BIST block's sw input directly, so that block's pattern/override decision never sees bounce or metastable values.

Parameters:
WIDTH, 4, number of switch bits.
SYNC_STAGES, 2, synchronizer flops per bit; legal values are 2 or more.
DB_CYCLES, 10, consecutive clk edges a synced value must differ from sw_db before sw_db accepts it; legal values are 1 or more. Use 10 for sim and 1_000_000 for 100 MHz hardware.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
sw_raw  input  WIDTH  raw, asynchronous switch pins.
sw_db  output  WIDTH  debounced switch levels; feeds the BIST sw input.
sw_rise  output  WIDTH  one-cycle pulse per bit when sw_db goes 0->1.
sw_fall  output  WIDTH  one-cycle pulse per bit when sw_db goes 1->0.
sw_any  output  1  OR of sw_db; equivalent to the BIST "user active" flag.
stable  output  1  high when every per-bit counter is 0, i.e. nothing is pending.

Behaviour:
- Reset: rst high asynchronously clears all of the following to 0:
  - synchronizer flops
  - counters
  - sw_db, sw_rise, sw_fall
  - Consequently sw_any=0 and stable=1.
- Synchronizer: per bit, a SYNC_STAGES-deep shift chain. s = last stage.
- Per-bit counter: width max(1,$clog2(DB_CYCLES)). On each clk edge:
  - if s == sw_db: cnt<=0 (any bounce back restarts the qualification);
  - else if cnt == DB_CYCLES-1: sw_db<=s, cnt<=0;
  - else cnt<=cnt+1.
- Latency: a raw level first captured at edge k appears on sw_db after edge k+SYNC_STAGES-1+DB_CYCLES. With defaults that is k+11.
- Edge pulses: sw_rise[i]/sw_fall[i] are registered. They are asserted in the same cycle sw_db[i] shows its new value and last exactly one cycle. They are never both high for one bit.
- Pulse width: a raw pulse shorter than DB_CYCLES synced cycles is fully rejected; no sw_db change and no edge pulse.
- Bit independence: bits are independent. Simultaneous changes on several bits with equal timing update in the same cycle, and their pulses coincide.
- Counter wrap: a counter never exceeds DB_CYCLES-1, so no wrap is possible.
- sw_any and stable are combinational from registered state; they have no extra latency.
- Reset mid-qualification: the pending change is discarded.
  - After release, a still-held switch requalifies from scratch and generates a normal sw_rise.
- DB_CYCLES=1: sw_db follows s with 1 cycle of delay; there is still no glitch path.

Optional Feature:
Macro SW_DEBOUNCE_CHGCNT_EN.
- Defined: adds output port chg_cnt [7:0]. It increments by 1 on any cycle where any sw_rise or sw_fall bit is high (one count per cycle, not per bit). It wraps 255->0 and resets to 0 on rst. This is used for on-board bounce/activity diagnostics.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (bist_pkg) holds:
  - SW_WIDTH=4
  - DB_CYCLES_SIM=10
  - DB_CYCLES_HW=1_000_000
  - SYNC_STAGES_DEF=2
- The BIST block and this block both use SW_WIDTH.
- One sub-module: sw_db_bit, covering one bit's synchronizer, counter, sw_db bit and rise/fall pulse. sw_debounce instantiates it in a generate loop over WIDTH and forms sw_any, stable and the optional chg_cnt.

Test Plan:
1. Reset then idle: rst=1 for 3 cycles, sw_raw=0 -> after release sw_db=0000, sw_any=0, stable=1, and no pulses for 50 cycles.
2. Clean press: sw_raw 0000->0101 at edge k -> sw_db=0101 after edge k+11; sw_rise=0101 for exactly that one cycle; stable=0 from edge k+2 to k+10, then 1.
3. Bounce reject: sw_raw[2] toggles 1/0 every 3 cycles for 40 cycles, then returns to 0 -> sw_db[2] stays 0, no sw_rise[2], and the counter never reaches 9.
4. Release: from sw_db=1111, sw_raw->1110 held -> after 11 edges sw_db=1110 and sw_fall=0001 for 1 cycle; sw_any stays 1.
5. Reset mid-op: sw_raw 0000->1000, rst pulsed at edge k+6 -> sw_db stays 0000. A full 11-cycle requalification after release gives sw_db=1000 and sw_rise=1000.
6. With SW_DEBOUNCE_CHGCNT_EN: apply 3 separate qualified changes plus one 2-bit simultaneous change -> chg_cnt=4.
